// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit
// Description : Pipelined immediate extender (SEXT / ZEXT / BRANCH / UPPER)
//               with valid/ready handshakes and a 2-entry result FIFO.
//               Optional macro IMM_EXT_STATS_EN adds the xfer_count port,
//               which counts output transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  localparam logic [1:0] C_MODE_SEXT   = 2'b00;
  localparam logic [1:0] C_MODE_ZEXT   = 2'b01;
  localparam logic [1:0] C_MODE_BRANCH = 2'b10;
  localparam logic [1:0] C_MODE_UPPER  = 2'b11;

  // BRANCH must never lose significant bits after the shift, so two spare
  // bits above the immediate are mandatory.
  generate
    if ((IN_W < 2) || (OUT_W < IN_W + 2)) begin : g_param_check
      $error("imm_extend_unit: requires IN_W >= 2 and OUT_W >= IN_W + 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [OUT_W-1:0] r_head;
  logic [OUT_W-1:0] r_tail;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_head_ext;
  logic             w_wr_head_tail;
  logic             w_wr_tail;

  // Handshake qualifiers; in_ready depends only on registered state and rst.
  assign in_ready  = (r_state != S_TWO) && !rst;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_head;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  // Combinational extension of the incoming immediate by mode.
  always_comb begin
    w_ext = w_sext;
    case (in_mode)
      C_MODE_SEXT:   w_ext = w_sext;
      C_MODE_ZEXT:   w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      C_MODE_BRANCH: w_ext = w_sext << 2;
      C_MODE_UPPER:  w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default:       w_ext = w_sext;
    endcase
  end

  // FIFO occupancy next-state and entry write selects.
  always_comb begin
    w_state_next   = r_state;
    w_wr_head_ext  = 1'b0;
    w_wr_head_tail = 1'b0;
    w_wr_tail      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_next  = S_ONE;
          w_wr_head_ext = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          // New result replaces the head that is leaving this cycle.
          w_wr_head_ext = 1'b1;
        end else if (w_push) begin
          w_state_next = S_TWO;
          w_wr_tail    = 1'b1;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_state_next   = S_ONE;
          w_wr_head_tail = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // State and buffer registers; reset discards any buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_head_ext) begin
        r_head <= w_ext;
      end else if (w_wr_head_tail) begin
        r_head <= r_tail;
      end
      if (w_wr_tail) begin
        r_tail <= w_ext;
      end
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [31:0] r_xfer_count;

  // Output-transfer counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= '0;
    end else if (w_pop) begin
      r_xfer_count <= r_xfer_count + 32'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate extender for the datapath. Takes an IN_W-bit immediate field plus a 2-bit mode and produces an OUT_W-bit operand: sign-extended, zero-extended, word-scaled branch offset, or upper-immediate. Sits between instruction decode and the ALU/branch-target operand mux. Uses valid/ready handshakes on both sides with a 2-entry output buffer, so it sustains one result per cycle under backpressure.

## Interface
Parameters:
- IN_W, 16, immediate field width; minimum 2.
- OUT_W, 32, result width; must satisfy OUT_W >= IN_W + 2 (elaboration error otherwise).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_imm/in_mode are valid.
- in_ready  output  1  unit can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- in_imm  input  IN_W  immediate field.
- in_mode  input  2  00 SEXT, 01 ZEXT, 10 BRANCH, 11 UPPER.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready at a rising edge.
- out_data  output  OUT_W  extended result, oldest entry in the buffer.
- xfer_count  output  32  accepted-result counter (present only with IMM_EXT_STATS_EN).

## Operation
- SEXT: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W; lower IN_W bits pass through.
- ZEXT: upper OUT_W-IN_W bits are 0.
- BRANCH: sign-extend, then shift left by 2; bits 1:0 = 0. Cannot overflow, given the OUT_W constraint.
- UPPER: in_imm placed at bits OUT_W-1..OUT_W-IN_W; lower OUT_W-IN_W bits = 0.
- Extension is computed combinationally from the input and written into the buffer on an accepted transfer. The buffer stores results, not raw immediates.
- The buffer is a 2-entry FIFO with states EMPTY, ONE and TWO:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to TWO. Pop only goes to EMPTY. Simultaneous push and pop stay in ONE; the new result replaces the popped head.
  - TWO: pop goes to ONE. Push is impossible because in_ready = 0.
- in_ready = (state != TWO) && !rst. It depends only on registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data = head entry.
- While out_valid && !out_ready, out_data is held stable.
- Order is strictly preserved (FIFO).

## Timing
- Latency is 1 cycle. Data accepted at edge N appears on out_data with out_valid = 1 immediately after edge N.
- Throughput is 1 result per cycle whenever out_ready stays high.
- A full stall costs no bubble: with state TWO, the cycle after out_ready rises in_ready returns to 1.
- Reset values:
  - state EMPTY; out_valid 0; out_data 0; both buffer entries 0; xfer_count 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation: buffered results are discarded with no output transfer. Handshakes presented in the same cycle as rst are ignored.
- Inputs presented while in_ready = 0 are not captured. The producer must hold them.

## Configuration
- IMM_EXT_STATS_EN defined:
  - Port xfer_count exists.
  - It increments by 1 on every output transfer (out_valid && out_ready), wraps from 0xFFFFFFFF to 0, and is cleared by rst.
- IMM_EXT_STATS_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- SEXT, out_ready = 1, IN_W = 16, OUT_W = 32:
  - 0x0FFF gives 0x00000FFF.
  - 0xF000 gives 0xFFFFF000.
  - Each result is valid one cycle after acceptance.
- Modes on imm 0xF000 and 0x1234:
  - ZEXT 0xF000 gives 0x0000F000.
  - BRANCH 0xFFFF gives 0xFFFFFFFC; BRANCH 0x0004 gives 0x00000010.
  - UPPER 0x1234 gives 0x12340000.
- Backpressure:
  - Hold out_ready = 0 and offer 3 inputs (0x0001, 0x0002, 0x0003) back-to-back.
  - Expect in_ready = 0 after 2 accepted, 0x0003 held by the producer, and out_data stable at 0x00000001.
  - Raise out_ready: expect outputs 1, 2, 3 in order on consecutive cycles with no bubble.
- Streaming with simultaneous push/pop in ONE:
  - Drive 8 sequential values with both ready signals high.
  - Expect 8 outputs on 8 consecutive cycles, state never reaching TWO.
- Reset mid-operation:
  - Fill to TWO, then assert rst for 1 cycle.
  - Expect out_valid = 0 and out_data = 0 after that edge, in_ready = 0 during rst and 1 after, and no stale data emitted.
- With IMM_EXT_STATS_EN:
  - After 5 output transfers, xfer_count = 5.
  - Force the counter to 0xFFFFFFFF; the next transfer gives 0.
  - rst clears it to 0.
